// File: rtl/xps2_keyq_if.sv
// Bus and receiver signal bundle for the PS/2 key-event queue.
// master: PS/2 receiver plus bus controller side; slave: the queue itself.
interface xps2_keyq_if;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        nonempty;

    modport master (
        output rx_valid, rx_byte, sel, we, addr, data_in,
        input  data_out, nonempty
    );

    modport slave (
        input  rx_valid, rx_byte, sel, we, addr, data_in,
        output data_out, nonempty
    );
endinterface

// File: rtl/xps2_keyq.sv
// PS/2 key-event queue: folds E0/F0 prefixes into {ext, brk, code} events
// and buffers them in a polled FIFO behind a small register window.
module xps2_keyq #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned TIMEOUT = 1000000
) (
    input logic         clk,
    input logic         rst,
    xps2_keyq_if.slave  bus
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          emit, ev_ext, ev_brk, is_ctrl;

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d, make_only_q, make_only_d;
    logic          full, empty, pop, push_req, push, ctrl_wr, flush, ovf_set;
    logic [31:0]   status;
    logic          unused_data;

    // Only the low three CTRL bits carry meaning.
    assign unused_data = ^bus.data_in[31:3];

    // Protocol control/ack bytes reset the prefix decoder without producing an event.
    always_comb begin
        is_ctrl = bus.rx_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    end

    // Prefix decoder next state, event emit and stale-prefix timeout.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        emit    = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (bus.rx_valid) begin
            tmo_d = '0;
            if (is_ctrl) begin
                state_d = StIdle;
            end else if (bus.rx_byte == 8'hE0) begin
                state_d = (state_q == StBrk || state_q == StExtBrk) ? StExtBrk : StExt;
            end else if (bus.rx_byte == 8'hF0) begin
                state_d = (state_q == StExt || state_q == StExtBrk) ? StExtBrk : StBrk;
            end else begin
                emit    = 1'b1;
                ev_ext  = (state_q == StExt) || (state_q == StExtBrk);
                ev_brk  = (state_q == StBrk) || (state_q == StExtBrk);
                state_d = StIdle;
            end
        end else if (state_q == StIdle) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = StIdle;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // FIFO control: flush beats push/pop, a pop frees room for a push when full.
    always_comb begin
        full     = (count_q == (AW + 1)'(DEPTH));
        empty    = (count_q == '0);
        pop      = bus.sel && !bus.we && (bus.addr == 2'd1) && !empty;
        ctrl_wr  = bus.sel && bus.we && (bus.addr == 2'd2);
        flush    = ctrl_wr && bus.data_in[0];
        push_req = emit && !(ev_brk && make_only_q);
        push     = push_req && !flush && (!full || pop);
        ovf_set  = push_req && !flush && full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + (AW + 1)'(1);
            else if (pop && !push) count_d = count_q - (AW + 1)'(1);
        end

        overflow_d = overflow_q;
        if (ctrl_wr && bus.data_in[1]) overflow_d = 1'b0;
        if (ovf_set)                   overflow_d = 1'b1;
        make_only_d = ctrl_wr ? bus.data_in[2] : make_only_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tmo_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            make_only_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            make_only_q <= make_only_d;
        end
    end

    // Entry storage; contents are never visible while the queue is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= {ev_ext, ev_brk, bus.rx_byte};
    end

    // Register read mux, combinational from addr.
    always_comb begin
        status              = '0;
        status[0]           = empty;
        status[1]           = full;
        status[2]           = overflow_q;
        status[8 +: AW + 1] = count_q;
        case (bus.addr)
            2'd0:    bus.data_out = status;
            2'd1:    bus.data_out = empty ? 32'h0 : {1'b1, 21'h0, mem_q[rd_ptr_q]};
            2'd2:    bus.data_out = {29'h0, make_only_q, 2'b00};
            default: bus.data_out = 32'h0;
        endcase
    end

    assign bus.nonempty = !empty;

endmodule

// File: tb/tb_xps2_keyq.sv
// Directed bench for xps2_keyq with an event-level reference model.
module tb_xps2_keyq;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 16;

    logic clk;
    logic rst;
    xps2_keyq_if bus ();

    xps2_keyq #(.DEPTH(DEPTH), .AW(3), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Reference model: pending-prefix flags, idle counter, event queue.
    int q[$];
    bit m_ovf, m_mo, m_ext, m_brk;
    int m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
        end
    endtask

    function automatic bit is_ctrl_byte(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
    endfunction

    task automatic model_step();
        bit push_req, pop, ctrl_wr;
        int ev;
        push_req = 0;
        ev = 0;
        if (rst) begin
            q.delete();
            m_ovf = 0; m_mo = 0; m_ext = 0; m_brk = 0; m_idle = 0;
            return;
        end
        if (bus.rx_valid) begin
            m_idle = 0;
            if (is_ctrl_byte(bus.rx_byte)) begin
                m_ext = 0; m_brk = 0;
            end else if (bus.rx_byte == 8'hE0) begin
                m_ext = 1;
            end else if (bus.rx_byte == 8'hF0) begin
                m_brk = 1;
            end else begin
                ev = int'(m_ext) * 512 + int'(m_brk) * 256 + int'(bus.rx_byte);
                push_req = !(m_brk && m_mo);
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_ext = 0; m_brk = 0; m_idle = 0;
            end
        end
        pop     = bus.sel && !bus.we && bus.addr == 2'd1 && q.size() > 0;
        ctrl_wr = bus.sel && bus.we && bus.addr == 2'd2;
        if (ctrl_wr && bus.data_in[1]) m_ovf = 0;
        if (ctrl_wr) m_mo = bus.data_in[2];
        if (ctrl_wr && bus.data_in[0]) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push_req) begin
                if (q.size() < DEPTH) q.push_back(ev);
                else m_ovf = 1;
            end
        end
    endtask

    function automatic logic [31:0] exp_dout(input logic [1:0] a);
        int sz;
        sz = q.size();
        case (a)
            2'd0: return 32'(sz * 256 + int'(m_ovf) * 4 + int'(sz == DEPTH) * 2 + int'(sz == 0));
            2'd1: return (sz > 0) ? (32'h8000_0000 | 32'(q[0])) : 32'h0;
            2'd2: return {29'h0, m_mo, 2'b00};
            default: return 32'h0;
        endcase
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_data_out", bus.data_out, exp_dout(bus.addr));
            chk("model_nonempty", {31'h0, bus.nonempty}, {31'h0, q.size() != 0});
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus_idle();
        bus.rx_valid = 0; bus.sel = 0; bus.we = 0; bus.addr = 2'd0; bus.data_in = 32'h0;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1; bus.rx_byte = b;
        step();
        bus.rx_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.sel = 0; bus.we = 0; bus.addr = a;
        #1;
        chk(name, bus.data_out, exp);
    endtask

    task automatic read_data(input string name, input logic [31:0] exp);
        bus.sel = 1; bus.we = 0; bus.addr = 2'd1;
        #1;
        chk(name, bus.data_out, exp);
        step();
        bus.sel = 0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] v);
        bus.sel = 1; bus.we = 1; bus.addr = a; bus.data_in = v;
        step();
        bus.sel = 0; bus.we = 0; bus.data_in = 32'h0;
    endtask

    initial begin
        bus_idle();
        bus.rx_byte = 8'h00;
        rst = 1;
        step();
        step();
        rst = 0;
        chk_en = 1;

        // Reset state.
        expect_reg("reset_status", 2'd0, 32'h0000_0001);
        expect_reg("reset_data", 2'd1, 32'h0);
        chk("reset_nonempty", {31'h0, bus.nonempty}, 32'h0);

        // Four prefix combinations.
        send(8'h1C);
        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        read_data("make", 32'h8000_001C);
        read_data("break", 32'h8000_011C);
        read_data("ext_make", 32'h8000_0275);
        read_data("ext_break", 32'h8000_0375);
        read_data("read_empty", 32'h0);
        expect_reg("drained_status", 2'd0, 32'h0000_0001);

        // Overflow with nine events into eight entries.
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        expect_reg("ovf_status", 2'd0, 32'h0000_0806);
        for (int i = 0; i < 8; i++) read_data("ovf_order", 32'h8000_0010 + 32'(i));
        read_data("ovf_ninth_absent", 32'h0);
        expect_reg("ovf_sticky", 2'd0, 32'h0000_0005);
        wr_reg(2'd2, 32'h2);
        expect_reg("ovf_cleared", 2'd0, 32'h0000_0001);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
        bus.rx_valid = 1; bus.rx_byte = 8'h28;
        bus.sel = 1; bus.we = 0; bus.addr = 2'd1;
        #1;
        chk("full_pushpop_head", bus.data_out, 32'h8000_0020);
        step();
        bus.rx_valid = 0; bus.sel = 0;
        expect_reg("full_pushpop_status", 2'd0, 32'h0000_0802);
        for (int i = 1; i < 9; i++) read_data("full_pushpop_order", 32'h8000_0020 + 32'(i));

        // Timeout: one short of the limit keeps ext, the full limit drops it.
        send(8'hE0); idle(TMO - 1); send(8'h1C);
        read_data("tmo_edge_kept", 32'h8000_021C);
        send(8'hE0); idle(TMO); send(8'h1C);
        read_data("tmo_expired", 32'h8000_001C);

        // Ack byte mid-sequence aborts the prefix.
        send(8'hF0); send(8'hFA);
        expect_reg("ack_no_push", 2'd0, 32'h0000_0001);
        send(8'h1C);
        read_data("ack_idle", 32'h8000_001C);

        // make_only filter.
        wr_reg(2'd2, 32'h4);
        expect_reg("ctrl_make_only", 2'd2, 32'h0000_0004);
        send(8'hF0); send(8'h1C); send(8'h1C);
        expect_reg("make_only_count", 2'd0, 32'h0000_0100);
        read_data("make_only_entry", 32'h8000_001C);

        // Flush beats a simultaneous push.
        send(8'h33);
        bus.rx_valid = 1; bus.rx_byte = 8'h44;
        wr_reg(2'd2, 32'h1);
        bus.rx_valid = 0;
        expect_reg("flush_wins", 2'd0, 32'h0000_0001);

        // Address 3 reads zero and ignores writes.
        wr_reg(2'd3, 32'hFFFF_FFFF);
        expect_reg("addr3_read", 2'd3, 32'h0);
        expect_reg("addr3_no_ctrl", 2'd2, 32'h0);

        // Reset mid-sequence with entries queued.
        wr_reg(2'd2, 32'h4);
        send(8'h01); send(8'h02); send(8'h03);
        send(8'hE0); send(8'hF0);
        rst = 1;
        step();
        rst = 0;
        expect_reg("rst_status", 2'd0, 32'h0000_0001);
        expect_reg("rst_ctrl", 2'd2, 32'h0);
        chk("rst_nonempty", {31'h0, bus.nonempty}, 32'h0);
        send(8'h75);
        read_data("rst_prefix_lost", 32'h8000_0075);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
